// File: rtl/heat_stream_pkg.sv
// Shared constants, defaults and FSM state type for the heatmap frame streamer.
package heat_stream_pkg;

    localparam logic [7:0] HDR_BYTE    = 8'hA5;
    localparam int         FRAME_BYTES = 35;
    localparam int         CELLS_DEF   = 64;
    localparam int         TEMP_W_DEF  = 4;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        TAG,
        FETCH_LO,
        FETCH_HI,
        PACK,
        EMIT,
        SUM,
        DONE
    } state_t;

endpackage

// File: rtl/heatmap_frame_streamer_if.sv
// Grid-store read port plus the valid/ready byte stream, bundled as one interface.
interface heatmap_frame_streamer_if #(
    parameter int TEMP_W = 4
);
    logic              rd_en;
    logic [5:0]        rd_addr;
    logic [TEMP_W-1:0] rd_data;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    // Streamer side: issues reads, produces the byte stream.
    modport master (
        output rd_en, rd_addr, out_data, out_valid, out_last,
        input  rd_data, out_ready
    );

    // Grid store / consumer side.
    modport slave (
        input  rd_en, rd_addr, out_data, out_valid, out_last,
        output rd_data, out_ready
    );
endinterface

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready holding register for the outgoing byte stream.
// A load always wins and leaves valid set; otherwise a transfer clears valid.
module stream_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         last,
    output logic         fire
);
    assign fire = valid & ready;

    // Hold data/last stable until the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
            last  <= load_last;
        end else if (fire) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end
endmodule

// File: rtl/heatmap_frame_streamer.sv
// Reads the temperature grid two cells at a time and streams a 35-byte frame:
// header, iteration tag, 32 nibble-packed cell bytes, mod-256 checksum.
module heatmap_frame_streamer
    import heat_stream_pkg::*;
#(
    parameter int CELLS  = CELLS_DEF,
    parameter int TEMP_W = TEMP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [15:0]              iter_tag,
    output logic                     busy,
    output logic [7:0]               frame_count,
    heatmap_frame_streamer_if.master bus
);
    localparam int            PAIRS  = CELLS / 2;
    localparam int            KW     = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(PAIRS - 1);

    state_t            state, state_nx;
    logic [KW-1:0]     k;
    logic [TEMP_W-1:0] lo_nib;
    logic [7:0]        tag_q;
    logic [7:0]        checksum;
    logic [7:0]        packed_byte;
    logic              ld;
    logic [7:0]        ld_data;
    logic              ld_last;
    logic              fire;
    logic [7:0]        o_data;
    logic              o_valid;
    logic              o_last;
    logic              unused_tag_hi;

    // Only the low byte of the iteration tag goes into the frame.
    assign unused_tag_hi = ^iter_tag[15:8];

    // rd_data in PACK is the odd (high) cell of the pair.
    assign packed_byte = 8'({bus.rd_data, lo_nib});

    stream_out_reg #(.W(8)) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (ld),
        .load_data (ld_data),
        .load_last (ld_last),
        .ready     (bus.out_ready),
        .data      (o_data),
        .valid     (o_valid),
        .last      (o_last),
        .fire      (fire)
    );

    assign bus.out_data  = o_data;
    assign bus.out_valid = o_valid;
    assign bus.out_last  = o_last;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; byte-emitting states wait for a transfer.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = HDR;
            HDR:      if (fire)  state_nx = TAG;
            TAG:      if (fire)  state_nx = FETCH_LO;
            FETCH_LO: state_nx = FETCH_HI;
            FETCH_HI: state_nx = PACK;
            PACK:     state_nx = EMIT;
            EMIT:     if (fire)  state_nx = (k == K_LAST) ? SUM : FETCH_LO;
            SUM:      if (fire)  state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Outputs: read strobes, busy, and loads into the output register.
    always_comb begin
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        busy        = (state != IDLE);
        ld          = 1'b0;
        ld_data     = '0;
        ld_last     = 1'b0;
        case (state)
            IDLE: if (start) begin
                ld      = 1'b1;
                ld_data = HDR_BYTE;
            end
            HDR: if (fire) begin
                ld      = 1'b1;
                ld_data = tag_q;
            end
            FETCH_LO: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = 6'({k, 1'b0});
            end
            FETCH_HI: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = 6'({k, 1'b1});
            end
            PACK: begin
                ld      = 1'b1;
                ld_data = packed_byte;
            end
            EMIT: if (fire && k == K_LAST) begin
                ld      = 1'b1;
                ld_data = checksum;
                ld_last = 1'b1;
            end
            default: ;
        endcase
    end

    // Frame datapath: tag capture, pair index, low nibble, checksum, frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k           <= '0;
            lo_nib      <= '0;
            tag_q       <= '0;
            checksum    <= '0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    tag_q    <= iter_tag[7:0];
                    checksum <= HDR_BYTE + iter_tag[7:0];
                    k        <= '0;
                end
                FETCH_HI: lo_nib   <= bus.rd_data;
                PACK:     checksum <= checksum + packed_byte;
                EMIT:     if (fire && k != K_LAST) k <= k + 1'b1;
                DONE:     frame_count <= frame_count + 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_heatmap_frame_streamer.sv
// Self-checking bench: table of directed frames, random frames against a
// frame-level reference model, plus reset-abort and counter-wrap sequences.
module tb_heatmap_frame_streamer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] iter_tag = '0;
    logic        busy;
    logic [7:0]  frame_count;

    heatmap_frame_streamer_if #(.TEMP_W(4)) bus();

    heatmap_frame_streamer #(.CELLS(64), .TEMP_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .iter_tag    (iter_tag),
        .busy        (busy),
        .frame_count (frame_count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Grid store: one-cycle read latency.
    logic [3:0] grid [64];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= grid[bus.rd_addr];

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    // A read must never be issued while a byte is waiting.
    always @(negedge clk) if (!rst && bus.out_valid && bus.rd_en) viol++;

    logic [7:0] exp_b [35];
    logic [7:0] got_b [40];
    logic       got_l [40];
    int         got_n;
    int         hold_bad;
    int         stall_left;
    logic [7:0] fc_m;

    typedef struct {
        int          pat;
        logic [15:0] tag;
        int          mode;
        int          stall_k;
        bit          restart;
        logic [7:0]  exp_sum;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_grid(input int pat);
        for (int i = 0; i < 64; i++) begin
            case (pat)
                0: grid[i] = 4'h0;
                1: grid[i] = 4'(i % 16);
                2: grid[i] = 4'hF;
                default: grid[i] = 4'($urandom);
            endcase
        end
    endtask

    // Reference frame computed straight from the cell values and tag.
    task automatic build_model(input logic [7:0] tag);
        int s;
        exp_b[0] = 8'hA5;
        exp_b[1] = tag;
        for (int p = 0; p < 32; p++)
            exp_b[2 + p] = 8'(int'(grid[2*p+1]) * 16 + int'(grid[2*p]));
        s = 0;
        for (int i = 0; i < 34; i++) s += int'(exp_b[i]);
        exp_b[34] = 8'(s % 256);
    endtask

    // mode 0: always ready, 1: random ready, 2: 10-cycle stall on packed byte stall_k.
    // abort_at>0: assert reset right after that many bytes have transferred.
    task automatic run_frame(input int mode, input int stall_k, input bit restart,
                             input logic [15:0] tag, input int abort_at);
        int         cyc;
        bit         done;
        bit         r;
        bit         prev_hold;
        logic [7:0] prev_data;
        logic       prev_last;
        got_n = 0; hold_bad = 0; cyc = 0; done = 0; prev_hold = 0;
        prev_data = '0; prev_last = 1'b0;
        stall_left = (mode == 2) ? 10 : 0;
        @(negedge clk);
        start = 1'b1;
        iter_tag = tag;
        bus.out_ready = 1'b1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = restart && (cyc == 40);
            iter_tag = 16'($urandom);
            if (prev_hold && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
                              bus.out_last !== prev_last)) hold_bad++;
            prev_hold = 0;
            if (bus.out_valid) begin
                r = 1;
                if (mode == 1) r = ($urandom_range(0, 2) != 0);
                if (mode == 2 && got_n == 2 + stall_k && stall_left > 0) begin
                    if (bus.rd_en) hold_bad++;
                    stall_left--;
                    r = 0;
                end
                bus.out_ready = r;
                if (r) begin
                    got_b[got_n] = bus.out_data;
                    got_l[got_n] = bus.out_last;
                    got_n++;
                    if (bus.out_last) done = 1;
                    if (abort_at > 0 && got_n == abort_at) begin
                        @(posedge clk);
                        #2 rst = 1'b1;
                        #1;
                        check("rst_valid", bus.out_valid, 0);
                        check("rst_last", bus.out_last, 0);
                        check("rst_data", bus.out_data, 0);
                        check("rst_rd_en", bus.rd_en, 0);
                        check("rst_rd_addr", bus.rd_addr, 0);
                        check("rst_busy", busy, 0);
                        check("rst_fc", frame_count, 0);
                        done = 1;
                    end
                end else begin
                    prev_hold = 1;
                    prev_data = bus.out_data;
                    prev_last = bus.out_last;
                end
            end else begin
                bus.out_ready = (mode == 1) ? 1'($urandom) : 1'b1;
            end
        end
        start = 1'b0;
        check("frame_done", done, 1);
    endtask

    // Compare the collected frame with the model, then DONE/IDLE behaviour.
    task automatic check_frame(input bit use_tab, input logic [7:0] tab_sum);
        int last_bad;
        check("frame_len", got_n, 35);
        for (int i = 0; i < 35 && i < got_n; i++)
            check($sformatf("byte%0d", i), got_b[i], exp_b[i]);
        last_bad = 0;
        for (int i = 0; i < got_n; i++)
            if (got_l[i] !== (i == 34)) last_bad++;
        check("last_flag", last_bad, 0);
        if (use_tab) check("checksum_tab", got_b[34], tab_sum);
        check("hold_stable", hold_bad, 0);
        check("rd_while_valid", viol, 0);
        @(negedge clk);
        check("done_valid", bus.out_valid, 0);
        @(negedge clk);
        fc_m = fc_m + 8'd1;
        check("idle_busy", busy, 0);
        check("frame_count", frame_count, fc_m);
    endtask

    initial begin
        vecs[0] = '{pat: 0, tag: 16'h0003, mode: 0, stall_k: 0, restart: 0, exp_sum: 8'hA8};
        vecs[1] = '{pat: 1, tag: 16'h0000, mode: 0, stall_k: 0, restart: 0, exp_sum: 8'h85};
        vecs[2] = '{pat: 1, tag: 16'h0000, mode: 2, stall_k: 5, restart: 0, exp_sum: 8'h85};
        vecs[3] = '{pat: 2, tag: 16'hAB12, mode: 0, stall_k: 0, restart: 0, exp_sum: 8'h97};
        vecs[4] = '{pat: 0, tag: 16'h7703, mode: 1, stall_k: 0, restart: 1, exp_sum: 8'hA8};

        bus.out_ready = 1'b0;
        fill_grid(0);
        #12;
        check("reset_valid", bus.out_valid, 0);
        check("reset_last", bus.out_last, 0);
        check("reset_data", bus.out_data, 0);
        check("reset_rd_en", bus.rd_en, 0);
        check("reset_rd_addr", bus.rd_addr, 0);
        check("reset_busy", busy, 0);
        check("reset_fc", frame_count, 0);
        @(negedge clk);
        rst = 1'b0;
        fc_m = 8'd0;

        for (int v = 0; v < 5; v++) begin
            fill_grid(vecs[v].pat);
            build_model(vecs[v].tag[7:0]);
            run_frame(vecs[v].mode, vecs[v].stall_k, vecs[v].restart, vecs[v].tag, 0);
            if (vecs[v].mode == 2) check("stall_len", stall_left, 0);
            check_frame(1'b1, vecs[v].exp_sum);
        end

        for (int f = 0; f < 4; f++) begin
            logic [15:0] t;
            t = 16'($urandom);
            fill_grid(3);
            build_model(t[7:0]);
            run_frame(1, 0, f[0], t, 0);
            check_frame(1'b0, 8'h00);
        end

        // Reset right after packed byte 10 (frame byte index 12) transfers.
        fill_grid(3);
        build_model(8'h5C);
        run_frame(0, 0, 0, 16'h125C, 13);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_valid", bus.out_valid, 0);
        end
        check("abort_fc", frame_count, 0);
        rst = 1'b0;
        fc_m = 8'd0;
        fill_grid(3);
        build_model(8'hE1);
        run_frame(0, 0, 0, 16'h00E1, 0);
        check_frame(1'b0, 8'h00);

        // 256 back-to-back frames from a fresh reset wrap the counter to zero.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fc_m = 8'd0;
        for (int f = 0; f < 256; f++) begin
            logic [15:0] t;
            t = 16'($urandom);
            fill_grid(3);
            build_model(t[7:0]);
            run_frame(0, 0, 0, t, 0);
            check_frame(1'b0, 8'h00);
        end
        check("fc_wrap", frame_count, fc_m);
        check("fc_wrap_zero", frame_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
